// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store sequencer: opcodes,
// funct3 encodings, FSM states and access-size helpers.
package mem_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  // Any funct3 outside the five defined load/store encodings behaves as a word.
  function automatic size_e accessSize(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: accessSize = SZ_B;
      F3_H, F3_HU: accessSize = SZ_H;
      default:     accessSize = SZ_W;
    endcase
  endfunction

  // Halfwords need an even address, words need a 4-byte aligned address.
  function automatic logic isMisaligned(input size_e size, input logic [1:0] offset);
    case (size)
      SZ_H:    isMisaligned = offset[0];
      SZ_W:    isMisaligned = |offset;
      default: isMisaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load data aligner: moves the addressed byte/halfword of a read word down
// to bit 0 and sign- or zero-extends it. Purely combinational so it can also
// sit on the DMA read path.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted;

  // Shift the lane down by the byte offset, then extend per funct3.
  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    case (funct3_i)
      F3_B:    result_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   result_o = {24'b0, shifted[7:0]};
      F3_H:    result_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   result_o = {16'b0, shifted[15:0]};
      default: result_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer. Decodes the instruction sitting in MEM,
// aligns store data, runs the request/response handshake with data memory,
// and holds the pipeline until the access has finished.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_RegM,
  input  logic [31:0] alu_out_out,
  input  logic [31:0] rs2_data_out,
  input  logic        stall_other,
  output logic        stall_mem,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_wstrb,
  output logic [31:0] dm_wdata,
  input  logic        dm_ready,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        we_q, we_d;
  logic        misalign_q, misalign_d;
  logic [1:0]  offset_q, offset_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] loadData_q, loadData_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  offset;
  logic        isLoad;
  logic        isStore;
  logic        isMem;
  size_e       size;
  logic        misaligned;
  logic [31:0] storeWdata;
  logic [3:0]  storeWstrb;
  logic [31:0] alignedLoad;

  // Register-number and immediate fields play no part in the memory access.
  logic unused_inst;
  assign unused_inst = ^{inst_RegM[31:15], inst_RegM[11:7]};

  // Decode the instruction currently held in MEM.
  always_comb begin
    opcode     = inst_RegM[6:0];
    funct3     = inst_RegM[14:12];
    offset     = alu_out_out[1:0];
    isLoad     = (opcode == OP_LOAD);
    isStore    = (opcode == OP_STORE);
    isMem      = isLoad | isStore;
    size       = accessSize(funct3);
    misaligned = isMisaligned(size, offset);
  end

  // Replicate store data into every lane and enable only the addressed bytes.
  always_comb begin
    storeWdata = rs2_data_out;
    storeWstrb = 4'b1111;
    case (size)
      SZ_B: begin
        storeWdata = {4{rs2_data_out[7:0]}};
        storeWstrb = 4'b0001 << offset;
      end
      SZ_H: begin
        storeWdata = {2{rs2_data_out[15:0]}};
        storeWstrb = 4'b0011 << offset;
      end
      default: begin
        storeWdata = rs2_data_out;
        storeWstrb = 4'b1111;
      end
    endcase
  end

  load_align uLoadAlign (
    .rdata_i  (dm_rdata),
    .offset_i (offset_q),
    .funct3_i (funct3_q),
    .result_o (alignedLoad)
  );

  // Next-state logic: bus fields are captured once on leaving IDLE so they
  // stay stable for the whole request even if the pipeline inputs wiggle.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    we_d       = we_q;
    misalign_d = misalign_q;
    offset_d   = offset_q;
    funct3_d   = funct3_q;
    loadData_d = loadData_q;
    case (state_q)
      IDLE: begin
        if (isMem) begin
          if (misaligned) begin
            misalign_d = 1'b1;
            state_d    = DONE;
          end else begin
            misalign_d = 1'b0;
            addr_d     = {alu_out_out[31:2], 2'b00};
            we_d       = isStore;
            wdata_d    = isStore ? storeWdata : 32'b0;
            wstrb_d    = isStore ? storeWstrb : 4'b0000;
            offset_d   = offset;
            funct3_d   = funct3;
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        if (dm_ready) begin
          state_d = we_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (dm_rvalid) begin
          loadData_d = alignedLoad;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (!stall_other) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured-access registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      we_q       <= 1'b0;
      misalign_q <= 1'b0;
      offset_q   <= '0;
      funct3_q   <= '0;
      loadData_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      we_q       <= we_d;
      misalign_q <= misalign_d;
      offset_q   <= offset_d;
      funct3_q   <= funct3_d;
      loadData_q <= loadData_d;
    end
  end

  // Stall is dropped in DONE so the pipeline advances exactly once per access.
  always_comb begin
    stall_mem  = ((state_q == IDLE) && isMem) || (state_q == REQ) || (state_q == WAIT);
    dm_req     = (state_q == REQ);
    dm_we      = we_q;
    dm_addr    = addr_q;
    dm_wstrb   = wstrb_q;
    dm_wdata   = wdata_q;
    load_data  = loadData_q;
    load_valid = (state_q == DONE) && !we_q && !misalign_q;
    misalign   = (state_q == DONE) && misalign_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit. Expected bus fields, load results and
// cycle counts come from an arithmetic model of the load/store rules; a few
// literal values pin that model to hand-worked examples.
module tb_mem_access_unit;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] LB  = 32'h00000003;
  localparam logic [31:0] LH  = 32'h00001003;
  localparam logic [31:0] LW  = 32'h00002003;
  localparam logic [31:0] LBU = 32'h00004003;
  localparam logic [31:0] LHU = 32'h00005003;
  localparam logic [31:0] SB  = 32'h00000023;
  localparam logic [31:0] SH  = 32'h00001023;
  localparam logic [31:0] SW  = 32'h00002023;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_RegM;
  logic [31:0] alu_out_out;
  logic [31:0] rs2_data_out;
  logic        stall_other;
  logic        stall_mem;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_wdata;
  logic        dm_ready;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misalign;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] lastAddr;
  logic [31:0] lastWdata;
  logic [3:0]  lastWstrb;
  logic [31:0] lastLoad;
  int          stallSeen;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk          (clk),
    .rst          (rst),
    .inst_RegM    (inst_RegM),
    .alu_out_out  (alu_out_out),
    .rs2_data_out (rs2_data_out),
    .stall_other  (stall_other),
    .stall_mem    (stall_mem),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_wstrb     (dm_wstrb),
    .dm_wdata     (dm_wdata),
    .dm_ready     (dm_ready),
    .dm_rvalid    (dm_rvalid),
    .dm_rdata     (dm_rdata),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .misalign     (misalign)
  );

  // Access width in bytes; unlisted funct3 values count as words.
  function automatic int sizeBytes(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic bit modelMisaligned(input logic [2:0] f3, input logic [31:0] addr);
    return (addr % sizeBytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] modelStrb(input logic [2:0] f3, input logic [31:0] addr);
    int n = sizeBytes(f3);
    if (n == 4) return 4'hF;
    return 4'(((1 << n) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] rs2);
    int n = sizeBytes(f3);
    if (n == 1) return 32'(rs2[7:0]) * 32'h01010101;
    if (n == 2) return 32'(rs2[15:0]) * 32'h00010001;
    return rs2;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] rdata);
    int n = sizeBytes(f3);
    logic [31:0] v;
    logic [31:0] mask;
    if (n == 4) return rdata;
    v    = rdata >> (8 * (addr % 4));
    mask = (32'd1 << (8 * n)) - 32'd1;
    v    = v & mask;
    if (!f3[2] && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Runs one access from IDLE through DONE and back to IDLE, checking every
  // cycle. readyDelay = REQ cycles with dm_ready low; waitCycles = WAIT
  // cycles including the one carrying dm_rvalid; holdCycles = DONE cycles
  // with stall_other high.
  task automatic applyStimulus(input string name, input logic [31:0] inst, input logic [31:0] addr,
                               input logic [31:0] rs2, input int readyDelay, input int waitCycles,
                               input logic [31:0] rdata, input int holdCycles);
    bit          isLoad;
    bit          isStore;
    bit          mis;
    bit          reqExp;
    logic [2:0]  f3;
    int          stallCycles;
    int          handshakes;
    isLoad  = (inst[6:0] == 7'b0000011);
    isStore = (inst[6:0] == 7'b0100011);
    f3      = inst[14:12];
    mis     = modelMisaligned(f3, addr);
    stallCycles = mis ? 1 : (isStore ? 2 + readyDelay : 2 + readyDelay + waitCycles);
    handshakes  = 0;
    stallSeen   = 0;

    for (int c = 0; c < stallCycles; c++) begin
      @(posedge clk); #1;
      inst_RegM    = inst;
      alu_out_out  = addr;
      rs2_data_out = rs2;
      stall_other  = 1'b0;
      dm_ready     = !mis && (c == 1 + readyDelay);
      dm_rvalid    = isLoad && !mis && (c == stallCycles - 1);
      dm_rdata     = dm_rvalid ? rdata : 32'hDEADBEEF;
      @(negedge clk);
      if (stall_mem) stallSeen++;
      checkOutput({name, " stall_mem"}, 32'(stall_mem), 32'd1);
      reqExp = !mis && (c >= 1) && (c <= 1 + readyDelay);
      checkOutput({name, " dm_req"}, 32'(dm_req), 32'(reqExp));
      if (reqExp) begin
        checkOutput({name, " dm_addr"}, dm_addr, {addr[31:2], 2'b00});
        checkOutput({name, " dm_we"}, 32'(dm_we), 32'(isStore));
        checkOutput({name, " dm_wstrb"}, 32'(dm_wstrb), isStore ? 32'(modelStrb(f3, addr)) : 32'd0);
        if (isStore) checkOutput({name, " dm_wdata"}, dm_wdata, modelWdata(f3, rs2));
        lastAddr  = dm_addr;
        lastWstrb = dm_wstrb;
        lastWdata = dm_wdata;
      end
      checkOutput({name, " load_valid early"}, 32'(load_valid), 32'd0);
      checkOutput({name, " misalign early"}, 32'(misalign), 32'd0);
      if (dm_req && dm_ready) handshakes++;
    end

    for (int d = 0; d <= holdCycles; d++) begin
      @(posedge clk); #1;
      stall_other = (d < holdCycles);
      dm_ready    = 1'b0;
      dm_rvalid   = 1'b0;
      dm_rdata    = 32'hDEADBEEF;
      @(negedge clk);
      if (stall_mem) stallSeen++;
      checkOutput({name, " done stall_mem"}, 32'(stall_mem), 32'd0);
      checkOutput({name, " done dm_req"}, 32'(dm_req), 32'd0);
      checkOutput({name, " load_valid"}, 32'(load_valid), 32'(isLoad && !mis));
      checkOutput({name, " misalign"}, 32'(misalign), 32'(mis));
      if (isLoad && !mis) begin
        checkOutput({name, " load_data"}, load_data, modelLoad(f3, addr, rdata));
        lastLoad = load_data;
      end
      if (dm_req && dm_ready) handshakes++;
    end

    // The pipeline advances past the instruction once DONE is left.
    @(posedge clk); #1;
    inst_RegM   = NOP;
    stall_other = 1'b0;
    @(negedge clk);
    if (stall_mem) stallSeen++;
    checkOutput({name, " idle stall_mem"}, 32'(stall_mem), 32'd0);
    checkOutput({name, " idle dm_req"}, 32'(dm_req), 32'd0);
    checkOutput({name, " idle load_valid"}, 32'(load_valid), 32'd0);
    checkOutput({name, " idle misalign"}, 32'(misalign), 32'd0);
    checkOutput({name, " handshakes"}, 32'(handshakes), mis ? 32'd0 : 32'd1);
  endtask

  // Cycle-count safety net in case the bench itself stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst          = 1'b1;
    inst_RegM    = NOP;
    alu_out_out  = '0;
    rs2_data_out = '0;
    stall_other  = 1'b0;
    dm_ready     = 1'b0;
    dm_rvalid    = 1'b0;
    dm_rdata     = '0;
    lastAddr     = '0;
    lastWdata    = '0;
    lastWstrb    = '0;
    lastLoad     = '0;
    stallSeen    = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset dm_req", 32'(dm_req), 32'd0);
    checkOutput("reset dm_we", 32'(dm_we), 32'd0);
    checkOutput("reset dm_addr", dm_addr, 32'd0);
    checkOutput("reset dm_wstrb", 32'(dm_wstrb), 32'd0);
    checkOutput("reset dm_wdata", dm_wdata, 32'd0);
    checkOutput("reset load_data", load_data, 32'd0);
    checkOutput("reset load_valid", 32'(load_valid), 32'd0);
    checkOutput("reset misalign", 32'(misalign), 32'd0);
    checkOutput("reset stall_mem", 32'(stall_mem), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    applyStimulus("SB", SB, 32'h00001003, 32'hAABBCCDD, 0, 0, 32'h0, 0);
    checkOutput("SB lit addr", lastAddr, 32'h00001000);
    checkOutput("SB lit wstrb", 32'(lastWstrb), 32'h8);
    checkOutput("SB lit wdata", lastWdata, 32'hDDDDDDDD);
    checkOutput("SB lit stall", 32'(stallSeen), 32'd2);

    applyStimulus("LB", LB, 32'h00002001, 32'h0, 0, 1, 32'h123480FF, 0);
    checkOutput("LB lit data", lastLoad, 32'hFFFFFF80);
    checkOutput("LB lit stall", 32'(stallSeen), 32'd3);

    applyStimulus("LBU", LBU, 32'h00002001, 32'h0, 0, 1, 32'h123480FF, 0);
    checkOutput("LBU lit data", lastLoad, 32'h00000080);

    applyStimulus("LW slow", LW, 32'h00003000, 32'h0, 3, 2, 32'hCAFEF00D, 0);
    checkOutput("LW lit data", lastLoad, 32'hCAFEF00D);
    checkOutput("LW lit stall", 32'(stallSeen), 32'd7);

    applyStimulus("LH mis", LH, 32'h00004001, 32'h0, 0, 0, 32'h0, 0);
    checkOutput("LH mis lit stall", 32'(stallSeen), 32'd1);

    applyStimulus("SW hold", SW, 32'h00005000, 32'h11223344, 0, 0, 32'h0, 4);
    checkOutput("SW lit wdata", lastWdata, 32'h11223344);

    applyStimulus("SH", SH, 32'h00006002, 32'h0000BEEF, 1, 0, 32'h0, 0);
    checkOutput("SH lit wstrb", 32'(lastWstrb), 32'hC);
    checkOutput("SH lit wdata", lastWdata, 32'hBEEFBEEF);

    applyStimulus("LHU", LHU, 32'h00007002, 32'h0, 0, 1, 32'h80011234, 0);
    checkOutput("LHU lit data", lastLoad, 32'h00008001);
    applyStimulus("LH", LH, 32'h00007002, 32'h0, 1, 3, 32'h80011234, 2);
    checkOutput("LH lit data", lastLoad, 32'hFFFF8001);

    applyStimulus("SW mis", SW, 32'h00008002, 32'h55667788, 0, 0, 32'h0, 2);
    applyStimulus("LB pos", LB, 32'h00009003, 32'h0, 2, 1, 32'h7F000000, 1);
    checkOutput("LB pos lit data", lastLoad, 32'h0000007F);

    // Reset while a load waits for read data: everything must clear and a
    // late rvalid must not resurrect the access.
    @(posedge clk); #1;
    inst_RegM   = LW;
    alu_out_out = 32'h0000A000;
    dm_ready    = 1'b0;
    dm_rvalid   = 1'b0;
    @(posedge clk); #1;
    dm_ready = 1'b1;
    @(posedge clk); #1;
    dm_ready = 1'b0;
    @(negedge clk);
    checkOutput("rstwait in WAIT stall", 32'(stall_mem), 32'd1);
    checkOutput("rstwait in WAIT dm_req", 32'(dm_req), 32'd0);
    @(posedge clk); #1;
    rst       = 1'b1;
    inst_RegM = NOP;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstwait stall_mem", 32'(stall_mem), 32'd0);
    checkOutput("rstwait dm_req", 32'(dm_req), 32'd0);
    checkOutput("rstwait dm_addr", dm_addr, 32'd0);
    checkOutput("rstwait dm_we", 32'(dm_we), 32'd0);
    checkOutput("rstwait load_valid", 32'(load_valid), 32'd0);
    checkOutput("rstwait load_data", load_data, 32'd0);
    @(posedge clk); #1;
    dm_rvalid = 1'b1;
    dm_rdata  = 32'h55555555;
    @(posedge clk); #1;
    dm_rvalid = 1'b0;
    @(negedge clk);
    checkOutput("late rvalid load_valid", 32'(load_valid), 32'd0);
    checkOutput("late rvalid load_data", load_data, 32'd0);
    checkOutput("late rvalid stall_mem", 32'(stall_mem), 32'd0);
    checkOutput("late rvalid dm_req", 32'(dm_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store sequencer that consumes the EXE/MEM pipeline register outputs and drives the data-memory bus. It decodes the instruction held in MEM, aligns store data, generates byte strobes, and runs a request/response handshake with data memory. It holds the pipeline through a stall output while the access is outstanding. On completion it returns the sign- or zero-extended load result to write-back.

## Interface
Parameters:
- none; all widths are fixed at 32-bit RV32.

Ports (clock and reset first):
- clk  input  1  system clock
- rst  input  1  reset; one clock; reset is synchronous and active-high
- inst_RegM  input  32  instruction in MEM; opcode [6:0], funct3 [14:12]
- alu_out_out  input  32  effective byte address
- rs2_data_out  input  32  raw store data
- stall_other  input  1  stall from any other source; the pipeline register holds while high
- stall_mem  output  1  request to hold IF..MEM; OR-ed into stall_IF
- dm_req  output  1  bus request valid
- dm_we  output  1  1 = store, 0 = load
- dm_addr  output  32  word address {addr[31:2],2'b00}
- dm_wstrb  output  4  byte enables; 0 for loads
- dm_wdata  output  32  lane-replicated store data
- dm_ready  input  1  request accepted this cycle
- dm_rvalid  input  1  read data valid; ignored outside WAIT
- dm_rdata  input  32  read word
- load_data  output  32  extended load result, registered
- load_valid  output  1  load_data valid, high in DONE for loads
- misalign  output  1  misaligned access flag, high in DONE only

## Operation
Decode:
- is_load: opcode 0000011; is_store: opcode 0100011; is_mem = is_load | is_store.
- funct3 000 B, 001 H, 010 W, 100 BU, 101 HU. Other funct3 values are treated as W.
- Misaligned: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]≠0.

State machine, with IDLE as the reset state:
- IDLE:
  - Not is_mem: stay in IDLE.
  - is_mem and misaligned: go to DONE with misalign=1 and no bus request.
  - is_mem and aligned: latch addr[1:0], funct3 and dm_we/addr/wdata/wstrb, then go to REQ.
- REQ: dm_req=1 with all bus fields held stable until dm_ready.
  - On dm_ready, a store goes to DONE and a load goes to WAIT.
- WAIT: on dm_rvalid, capture the extended dm_rdata into load_data and go to DONE.
- DONE:
  - stall_other=1: stay in DONE. The same instruction is still in MEM and must not be re-issued.
  - stall_other=0: go to IDLE.

Store alignment (offset o = addr[1:0]):
- SB: wdata={4{rs2[7:0]}}, wstrb=0001<<o.
- SH: wdata={2{rs2[15:0]}}, wstrb=0011<<o.
- SW: wdata=rs2, wstrb=1111.

Load extraction: shift dm_rdata right by 8·o, then sign-extend (B/H) or zero-extend (BU/HU) from bit 7 or 15. W passes through unchanged.

stall_mem is combinational: (IDLE & is_mem) | REQ | WAIT. It is low in DONE so the pipeline advances exactly once.

## Timing
- Reset: state IDLE; dm_req, dm_we, dm_wstrb, dm_addr, dm_wdata, load_data, load_valid and misalign are all 0.
- Reset asserted mid-access drops dm_req on the next edge with no completion. The bus owner must discard the in-flight request.
- Store with zero-wait ready: stall high for 2 cycles (IDLE, REQ), DONE in the 3rd cycle.
- Load with zero-wait ready and rvalid one cycle later: stall high for 3 cycles, load_valid in the 4th.
- Each cycle of dm_ready=0 in REQ, or dm_rvalid=0 in WAIT, adds one stall cycle.
- The bus must assert dm_rvalid no earlier than the cycle after dm_ready.
- load_valid and misalign stay high for every DONE cycle, which can be more than one cycle under stall_other.

## Structure
- Package mem_pkg: opcode constants (OP_LOAD, OP_STORE), funct3 enum, state enum {IDLE, REQ, WAIT, DONE}.
- Sub-module load_align: combinational rdata, offset, funct3 → extended 32-bit result. It is reusable by the DMA read path.
- Store alignment and the FSM live in the top module.

## Test plan
- SB with addr 0x1003 and rs2 0xAABBCCDD, ready immediate → dm_addr 0x1000, wstrb 1000, wdata 0xDDDDDDDD; stall for 2 cycles, then DONE.
- LB at addr 0x2001 with rdata 0x1234_80FF → load_data 0xFFFFFF80. LBU at the same address → 0x00000080. Both raise load_valid in cycle 4.
- LW at 0x3000 with dm_ready low for 3 cycles and rvalid 2 cycles later → stall high for exactly 7 cycles. dm_req and dm_addr stay stable throughout REQ.
- LH at 0x4001 → misalign=1 in DONE, dm_req never asserted, stall for 1 cycle.
- Store completes while stall_other is held for 4 cycles → remains in DONE, with exactly one dm_req/dm_ready handshake.
- rst asserted in WAIT → next cycle state is IDLE with all outputs 0. A later rvalid pulse is ignored.
